// File: rtl/aes_pkg.sv
// Shared definitions for the AES round-constant sequencer: key-size encodings,
// FSM states, per-key-size rcon step counts and the GF(2^8) reduction constant.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128  = 2'd0,
        KL_192  = 2'd1,
        KL_256  = 2'd2,
        KL_RSVD = 2'd3
    } aes_keylen_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } aes_state_e;

    localparam logic [3:0] N_STEPS_128 = 4'd10;
    localparam logic [3:0] N_STEPS_192 = 4'd8;
    localparam logic [3:0] N_STEPS_256 = 4'd7;

    localparam logic [7:0] XTIME_POLY = 8'h1b;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    // The reserved encoding runs as AES-128.
    function automatic aes_keylen_e norm_keylen(input logic [1:0] kl);
        return (kl == 2'd3) ? KL_128 : aes_keylen_e'(kl);
    endfunction

    function automatic logic [3:0] rcon_steps(input aes_keylen_e kl);
        case (kl)
            KL_192:  return N_STEPS_192;
            KL_256:  return N_STEPS_256;
            default: return N_STEPS_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_xtime.sv
// Combinational GF(2^8) multiply-by-2 (xtime) over the AES polynomial.
module aes_xtime
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);

endmodule

// File: rtl/aes_rcon_seq.sv
// AES key-schedule round-constant sequencer for AES-128/192/256.
// Optional sticky error flag enabled by defining AES_RCON_ERR_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, no schedule loaded, outputs quiet
// RUN    | schedule active, rcon/sub_only presented until step
// DONE   | schedule finished, rnd holds final count until next kld
module aes_rcon_seq
    import aes_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kld,
    input  logic [1:0]       keylen,
    input  logic             step,
    output logic [OUT_W-1:0] rcon,
    output logic             rcon_valid,
    output logic             sub_only,
    output logic [3:0]       rnd,
    output logic             last,
    output logic             done,
    output logic             err
);

    aes_state_e  state_q, state_d;
    aes_keylen_e kl_q;
    logic [7:0]  rcon_q;
    logic [7:0]  rcon_nxt;
    logic [7:0]  rcon_byte;
    logic [3:0]  rnd_q;
    logic        phase_q;
    logic        is_256;
    logic        last_int;
    logic        run_step;

    aes_xtime u_xtime (
        .a (rcon_q),
        .y (rcon_nxt)
    );

    assign is_256   = (kl_q == KL_256);
    assign last_int = (state_q == S_RUN) && !phase_q
                      && (rnd_q == rcon_steps(kl_q) - 4'd1);
    assign run_step = (state_q == S_RUN) && step && !kld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kld) begin
            state_d = S_RUN;
        end else if (run_step && last_int) begin
            state_d = S_DONE;
        end
    end

    // AES-256 interleaves a SubWord-only step after every rcon step:
    // leaving phase 0 bumps rnd, leaving phase 1 advances rcon.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcon_q  <= RCON_INIT;
            rnd_q   <= 4'd0;
            phase_q <= 1'b0;
            kl_q    <= KL_128;
        end else if (kld) begin
            rcon_q  <= RCON_INIT;
            rnd_q   <= 4'd0;
            phase_q <= 1'b0;
            kl_q    <= norm_keylen(keylen);
        end else if (run_step) begin
            if (is_256) begin
                phase_q <= !phase_q;
                if (!phase_q) begin
                    rnd_q <= rnd_q + 4'd1;
                end else begin
                    rcon_q <= rcon_nxt;
                end
            end else begin
                rcon_q <= rcon_nxt;
                rnd_q  <= rnd_q + 4'd1;
            end
        end
    end

    always_comb begin
        rcon_valid = 1'b0;
        sub_only   = 1'b0;
        last       = 1'b0;
        done       = 1'b0;
        rcon_byte  = 8'h00;
        case (state_q)
            S_RUN: begin
                rcon_valid = 1'b1;
                sub_only   = is_256 && phase_q;
                last       = last_int;
                rcon_byte  = (is_256 && phase_q) ? 8'h00 : rcon_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rcon = OUT_W'(rcon_byte) << (OUT_W - 8);
    assign rnd  = rnd_q;

`ifdef AES_RCON_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (kld) begin
            err_q <= (keylen == 2'd3);
        end else if (step && (state_q != S_RUN)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Scoreboard bench for aes_rcon_seq: a step-count reference model queues the
// expected outputs per cycle and a monitor compares both a 32-bit and 8-bit build.
module tb_aes_rcon_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kld = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  keylen = 2'd0;

    logic [31:0] rcon;
    logic        rcon_valid, sub_only, last, done, err;
    logic [3:0]  rnd;

    logic [7:0]  rcon8;
    logic        rcon_valid8, sub_only8, last8, done8, err8;
    logic [3:0]  rnd8;

    aes_rcon_seq #(.OUT_W(32)) dut (
        .clk(clk), .rst(rst), .kld(kld), .keylen(keylen), .step(step),
        .rcon(rcon), .rcon_valid(rcon_valid), .sub_only(sub_only),
        .rnd(rnd), .last(last), .done(done), .err(err)
    );

    aes_rcon_seq #(.OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .kld(kld), .keylen(keylen), .step(step),
        .rcon(rcon8), .rcon_valid(rcon_valid8), .sub_only(sub_only8),
        .rnd(rnd8), .last(last8), .done(done8), .err(err8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rcon_b;
        logic       valid;
        logic       sub;
        logic [3:0] rnd;
        logic       last;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Model state: mode 0=idle 1=run 2=done; m_k = steps taken since kld.
    int m_mode = 0;
    int m_k    = 0;
    int m_kl   = 0;
    bit m_err  = 1'b0;

    function automatic int total_steps(input int kl);
        if (kl == 1) return 8;
        if (kl == 2) return 13;
        return 10;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    task automatic cyc(input bit r, input bit l, input logic [1:0] kl, input bit s);
        exp_t e;
        @(negedge clk);
        rst = r; kld = l; keylen = kl; step = s;
        if (r) begin
            m_mode = 0; m_k = 0; m_kl = 0; m_err = 1'b0;
        end else if (l) begin
            m_mode = 1; m_k = 0;
            m_kl   = (kl == 2'd3) ? 0 : int'(kl);
            m_err  = (kl == 2'd3);
        end else if (s) begin
            if (m_mode == 1) begin
                m_k++;
                if (m_k == total_steps(m_kl)) m_mode = 2;
            end else begin
                m_err = 1'b1;
            end
        end
        e.rcon_b = 8'h00; e.valid = 1'b0; e.sub = 1'b0; e.rnd = 4'd0;
        e.last = 1'b0; e.done = 1'b0;
        if (m_mode == 1) begin
            e.valid = 1'b1;
            e.last  = (m_k == total_steps(m_kl) - 1);
            if (m_kl == 2) begin
                e.sub    = (m_k % 2 == 1);
                e.rcon_b = e.sub ? 8'h00 : rcon_tab[m_k / 2];
                e.rnd    = 4'((m_k + 1) / 2);
            end else begin
                e.rcon_b = rcon_tab[m_k];
                e.rnd    = 4'(m_k);
            end
        end else if (m_mode == 2) begin
            e.done = 1'b1;
            e.rnd  = (m_kl == 2) ? 4'((m_k + 1) / 2) : 4'(m_k);
        end
`ifdef AES_RCON_ERR_EN
        e.err = m_err;
`else
        e.err = 1'b0;
`endif
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rcon",       rcon, {e.rcon_b, 24'h0});
                chk("rcon_valid", 32'(rcon_valid), 32'(e.valid));
                chk("sub_only",   32'(sub_only), 32'(e.sub));
                chk("rnd",        32'(rnd), 32'(e.rnd));
                chk("last",       32'(last), 32'(e.last));
                chk("done",       32'(done), 32'(e.done));
                chk("err",        32'(err), 32'(e.err));
                chk("rcon8",      32'(rcon8), 32'(e.rcon_b));
                chk("rnd8",       32'(rnd8), 32'(e.rnd));
                chk("done8",      32'(done8), 32'(e.done));
                chk("last8",      32'(last8), 32'(e.last));
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);                         // step in IDLE
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);                         // AES-128 full run
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 2, 1);                         // step in DONE
        cyc(0, 1, 2, 0);                         // AES-256 full run
        for (int i = 0; i < 13; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 0);                         // AES-192, restart with kld+step
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 1);
        for (int i = 0; i < 9; i++) cyc(0, 0, 3, 1);
        cyc(0, 1, 0, 0);                         // reset mid-sequence at 0x08
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 3, 0);                         // reserved keylen
        for (int i = 0; i < 11; i++) cyc(0, 0, 2, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        cyc(0, 0, 0, 0);
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
